// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   State encoding, iteration counts, counter width and a two's-complement
//   conditional-negate helper used by the signed divide path.
//   Optional feature macro: MULTDIV_REMAINDER_EN (consumed by the interface/top).
package multdiv_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned MULT_ITERS = WIDTH / 2;
  localparam int unsigned DIV_ITERS  = WIDTH;
  localparam int unsigned CNT_W      = 5;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Two's-complement negate when neg is set; maps INT_MIN onto itself.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: operand/control/result bundle between the execute stage and
//   the multiply/divide unit.
//   master: drives data_operandA/B, ctrl_MULT, ctrl_DIV; observes results.
//   slave : the unit; drives data_result, data_exception, data_resultRDY, busy
//           and, with MULTDIV_REMAINDER_EN defined, data_remainder.
interface multdiv_unit_if;
  import multdiv_pkg::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
    , input data_remainder
`endif
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
    , output data_remainder
`endif
  );

endinterface

// File: rtl/multdiv_unit_iter_counter.sv
// iter_counter: 5-bit iteration counter shared by the Booth and divide loops.
//   clk         : rising-edge clock
//   clr         : synchronous active-high reset
//   en_i        : increment this cycle
//   load_zero_i : force to zero (wins over en_i)
//   count_o     : current count
module iter_counter
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en_i,
  input  logic             load_zero_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (load_zero_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply (radix-4 Booth, 16 steps) and
//   divide (non-restoring on magnitudes, 32 steps).
//   clk : rising-edge clock
//   clr : synchronous active-high reset
//   bus : multdiv_unit_if.slave -- operands, ctrl_MULT/ctrl_DIV start pulses,
//         data_result, data_exception, one-cycle data_resultRDY, busy.
//   Optional feature macro MULTDIV_REMAINDER_EN adds bus.data_remainder.
//   Timing: the cycle after a start pulse is a setup cycle (loads the product
//   register or divide magnitudes), then one step per cycle; DONE is entered
//   with the result registered from the final step.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  multdiv_unit_if.slave bus
);

  state_e state_q, state_d;

  logic             start_mul, start_div, iterate, last_iter;
  logic             cnt_en, cnt_load0;
  logic [CNT_W-1:0] cnt_q;

  logic             setup_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [2*WIDTH:0] prod_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, dvsr_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, rdy_q, busy_q;

  iter_counter u_cnt (
    .clk         (clk),
    .clr         (clr),
    .en_i        (cnt_en),
    .load_zero_i (cnt_load0),
    .count_o     (cnt_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; a start pulse in any state restarts, multiply has priority.
  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    start_div = 1'b0;
    iterate   = 1'b0;
    last_iter = 1'b0;
    if (bus.ctrl_MULT) begin
      start_mul = 1'b1;
      state_d   = MULT;
    end else if (bus.ctrl_DIV) begin
      start_div = 1'b1;
      state_d   = DIV;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        MULT: begin
          if (!setup_q) begin
            iterate = 1'b1;
            if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
              last_iter = 1'b1;
              state_d   = DONE;
            end
          end
        end
        DIV: begin
          if (!setup_q) begin
            iterate = 1'b1;
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
              last_iter = 1'b1;
              state_d   = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cnt_en    = iterate;
    cnt_load0 = start_mul | start_div | last_iter;
  end

  // Radix-4 Booth step on {acc, multiplier, guard}; sum kept at 34 bits so +/-2M cannot wrap.
  logic [WIDTH+1:0] mc_ext, mc2, booth_add, acc_sum;
  logic [2*WIDTH:0] prod_step;
  logic [WIDTH-1:0] mul_res, mul_hi;
  logic             mul_exc;

  always_comb begin
    mc_ext = {{2{op_a_q[WIDTH-1]}}, op_a_q};
    mc2    = {mc_ext[WIDTH:0], 1'b0};
    case (prod_q[2:0])
      3'b001, 3'b010: booth_add = mc_ext;
      3'b011:         booth_add = mc2;
      3'b100:         booth_add = ~mc2 + (WIDTH+2)'(1);
      3'b101, 3'b110: booth_add = ~mc_ext + (WIDTH+2)'(1);
      default:        booth_add = '0;
    endcase
    acc_sum   = {{2{prod_q[2*WIDTH]}}, prod_q[2*WIDTH:WIDTH+1]} + booth_add;
    prod_step = {acc_sum, prod_q[WIDTH:2]};
    mul_res   = prod_step[WIDTH:1];
    mul_hi    = prod_step[2*WIDTH:WIDTH+1];
    mul_exc   = (mul_hi != {WIDTH{mul_res[WIDTH-1]}});
  end

  // Non-restoring divide step on magnitudes plus signed result fix-up.
  logic [WIDTH:0]   rem_shift, rem_step;
  logic [WIDTH-1:0] quo_step, div_res;
  logic             div_by_zero, div_ovf, div_exc;

  always_comb begin
    rem_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_step    = rem_q[WIDTH] ? (rem_shift + {1'b0, dvsr_q})
                               : (rem_shift - {1'b0, dvsr_q});
    quo_step    = {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
    div_by_zero = (op_b_q == '0);
    div_ovf     = (op_a_q == INT_MIN) && (op_b_q == '1);
    div_exc     = div_by_zero | div_ovf;
    div_res     = div_by_zero ? '0 : neg_if(quo_step, op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
  end

`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_fix, rem_signed, remainder_q;

  // Final restore of a negative partial remainder, then give it the dividend's sign.
  always_comb begin
    rem_fix    = rem_step[WIDTH] ? (rem_step[WIDTH-1:0] + dvsr_q) : rem_step[WIDTH-1:0];
    rem_signed = div_by_zero ? '0 : neg_if(rem_fix, op_a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      remainder_q <= '0;
    end else if (last_iter) begin
      remainder_q <= (state_q == DIV) ? rem_signed : '0;
    end
  end

  assign bus.data_remainder = remainder_q;
`endif

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      setup_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q   <= (state_d == DONE);
      busy_q  <= (state_d == MULT) || (state_d == DIV);
      setup_q <= start_mul | start_div;

      if (start_mul | start_div) begin
        op_a_q <= bus.data_operandA;
        op_b_q <= bus.data_operandB;
      end

      if (setup_q && !start_mul && !start_div) begin
        if (state_q == MULT) begin
          prod_q <= {{WIDTH{1'b0}}, op_b_q, 1'b0};
        end else if (state_q == DIV) begin
          rem_q  <= '0;
          quo_q  <= neg_if(op_a_q, op_a_q[WIDTH-1]);
          dvsr_q <= neg_if(op_b_q, op_b_q[WIDTH-1]);
        end
      end

      if (iterate) begin
        if (state_q == MULT) begin
          prod_q <= prod_step;
        end else begin
          rem_q <= rem_step;
          quo_q <= quo_step;
        end
      end

      if (last_iter) begin
        result_q <= (state_q == MULT) ? mul_res : div_res;
        exc_q    <= (state_q == MULT) ? mul_exc : div_exc;
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit. Expected results come from
// a behavioural signed multiply/divide model, are queued at start and popped at
// the ready pulse. Edge k is counted from the edge that samples the start pulse.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multdiv_unit_if bus ();

  multdiv_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  function automatic exp_t model(input bit mul, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] p;
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    e.rem = 32'h0;
    if (mul) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      e.res = p[31:0];
      e.exc = (p[63:32] != {32{p[31]}});
      e.lat = 17;
    end else begin
      e.lat = 33;
      if (b == 32'h0) begin
        e.res = 32'h0;
        e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = 32'h8000_0000;
        e.exc = 1'b1;
      end else begin
        e.res = sa / sb_;
        e.rem = sa % sb_;
        e.exc = 1'b0;
      end
    end
    return e;
  endfunction

  // Drive a start pulse at the current negedge; returns at the negedge after edge 0.
  task automatic start_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                          output int t0);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT = (mode != 1);
    bus.ctrl_DIV  = (mode != 0);
    t0 = cyc;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Start, queue the expectation, and wait (bounded) for the ready pulse.
  task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                        output int k, output bit ok, output logic busy0);
    int t0;
    start_op(mode, a, b, t0);
    sb.push_back(model(mode != 1, a, b));
    busy0 = bus.busy;
    ok = 1'b0;
    k = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.data_resultRDY === 1'b1) begin
        ok = 1'b1;
        k = cyc - t0 - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    repeat (3) @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    clr = 1'b0;
    total++; if (bus.data_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.data_result); end
    total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b want=0", bus.data_exception); end
    total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.data_resultRDY); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
`ifdef MULTDIV_REMAINDER_EN
    total++; if (bus.data_remainder !== 32'h0) begin bad++; $display("FAIL reset_rem got=%h want=0", bus.data_remainder); end
`endif
  endtask

  task automatic test_mult();
    logic [31:0] ta[4] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tb_[4] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'h8000_0000};
    int k; bit ok; logic busy0; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(0, ta[i], tb_[i], k, ok, busy0);
      e = sb.pop_front();
      total++; if (!ok) begin bad++; $display("FAIL mult_timeout case=%0d no ready pulse", i); continue; end
      total++; if (k != e.lat) begin bad++; $display("FAIL mult_latency case=%0d got=%0d want=%0d", i, k, e.lat); end
      total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL mult_result case=%0d got=%h want=%h", i, bus.data_result, e.res); end
      total++; if (bus.data_exception !== e.exc) begin bad++; $display("FAIL mult_exc case=%0d got=%b want=%b", i, bus.data_exception, e.exc); end
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mult_busy_start case=%0d got=%b want=1", i, busy0); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done case=%0d got=%b want=0", i, bus.busy); end
`ifdef MULTDIV_REMAINDER_EN
      total++; if (bus.data_remainder !== 32'h0) begin bad++; $display("FAIL mult_rem case=%0d got=%h want=0", i, bus.data_remainder); end
`endif
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_divide();
    logic [31:0] ta[7] = '{32'hFFFF_FFF9, 32'd100, 32'hFFFF_FF9C, 32'd7,
                           32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb_[7] = '{32'd2, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                            32'd0, 32'hFFFF_FFFF, 32'd3};
    int k; bit ok; logic busy0; exp_t e;
    for (int i = 0; i < 7; i++) begin
      run_op(1, ta[i], tb_[i], k, ok, busy0);
      e = sb.pop_front();
      total++; if (!ok) begin bad++; $display("FAIL div_timeout case=%0d no ready pulse", i); continue; end
      total++; if (k != e.lat) begin bad++; $display("FAIL div_latency case=%0d got=%0d want=%0d", i, k, e.lat); end
      total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL div_result case=%0d got=%h want=%h", i, bus.data_result, e.res); end
      total++; if (bus.data_exception !== e.exc) begin bad++; $display("FAIL div_exc case=%0d got=%b want=%b", i, bus.data_exception, e.exc); end
`ifdef MULTDIV_REMAINDER_EN
      total++; if (bus.data_remainder !== e.rem) begin bad++; $display("FAIL div_rem case=%0d got=%h want=%h", i, bus.data_remainder, e.rem); end
`endif
      @(negedge clk);
      total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL div_rdy_width case=%0d got=%b want=0", i, bus.data_resultRDY); end
      total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL div_hold case=%0d got=%h want=%h", i, bus.data_result, e.res); end
    end
  endtask

  task automatic test_both();
    int k; bit ok; logic busy0; exp_t e;
    run_op(2, 32'd6, 32'd7, k, ok, busy0);
    e = sb.pop_front();
    total++; if (!ok || k != e.lat) begin bad++; $display("FAIL both_latency got=%0d want=%0d", k, e.lat); end
    total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL both_result got=%h want=%h", bus.data_result, e.res); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int t0, t1, pulses, edge_k; exp_t e;
    start_op(0, 32'd5, 32'd9, t0);
    repeat (4) @(negedge clk);
    start_op(1, 32'd100, 32'd7, t1);
    sb.push_back(model(1'b0, 32'd100, 32'd7));
    pulses = 0;
    edge_k = -1;
    for (int i = 5; i <= 45; i++) begin
      if (bus.data_resultRDY === 1'b1) begin pulses++; edge_k = cyc - t0 - 1; end
      @(negedge clk);
    end
    e = sb.pop_front();
    total++; if (pulses != 1) begin bad++; $display("FAIL abort_pulses got=%0d want=1", pulses); end
    total++; if (edge_k != 5 + e.lat) begin bad++; $display("FAIL abort_edge got=%0d want=%0d", edge_k, 5 + e.lat); end
    total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL abort_result got=%h want=%h", bus.data_result, e.res); end
  endtask

  task automatic test_reset_midop();
    int t0, t1, pulses, edge_k; exp_t e;
    start_op(1, 32'd1000, 32'd3, t0);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++; if (bus.data_result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h want=0", bus.data_result); end
    total++; if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0 || bus.data_exception !== 1'b0) begin
      bad++; $display("FAIL midreset_flags busy=%b rdy=%b exc=%b want=000", bus.busy, bus.data_resultRDY, bus.data_exception); end
    @(negedge clk);
    start_op(0, 32'd3, 32'd3, t1);
    sb.push_back(model(1'b1, 32'd3, 32'd3));
    pulses = 0;
    edge_k = -1;
    for (int i = 12; i <= 45; i++) begin
      if (bus.data_resultRDY === 1'b1) begin pulses++; edge_k = cyc - t0 - 1; end
      @(negedge clk);
    end
    e = sb.pop_front();
    total++; if (pulses != 1) begin bad++; $display("FAIL midreset_pulses got=%0d want=1", pulses); end
    total++; if (edge_k != 12 + e.lat) begin bad++; $display("FAIL midreset_edge got=%0d want=%0d", edge_k, 12 + e.lat); end
    total++; if (bus.data_result !== e.res) begin bad++; $display("FAIL midreset_result2 got=%h want=%h", bus.data_result, e.res); end
  endtask

  // Each new op starts while the previous one is still in DONE.
  task automatic test_back_to_back();
    int k; bit ok; logic busy0; exp_t e;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 3 == 2) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) a = 32'($signed(a) >>> 8);
      run_op(i % 2, a, b, k, ok, busy0);
      e = sb.pop_front();
      total++; if (!ok || k != e.lat) begin bad++; $display("FAIL b2b_latency case=%0d got=%0d want=%0d", i, k, e.lat); end
      total++; if (bus.data_result !== e.res || bus.data_exception !== e.exc) begin
        bad++; $display("FAIL b2b_result case=%0d a=%h b=%h got=%h/%b want=%h/%b", i, a, b,
                        bus.data_result, bus.data_exception, e.res, e.exc); end
`ifdef MULTDIV_REMAINDER_EN
      total++; if (bus.data_remainder !== e.rem) begin bad++; $display("FAIL b2b_rem case=%0d got=%h want=%h", i, bus.data_remainder, e.rem); end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_divide();
    test_both();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
